tp_sequencer: RTL

Frame-synchronous controller for the test pattern generator in the PPU video path. Accepts pattern-select requests from the configuration side over a four-phase req/ack handshake and applies them only on a falling edge of nVSYNC, so a frame never mixes two patterns. Optionally auto-cycles through the non-off patterns after a fixed number of frames (PAL/NTSC dependent). It drives the pattern select and enable inputs of the generator stage.

---
 rtl/tp_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/tp_sequencer.sv
// Frame-synchronous test pattern sequencer: applies configuration requests on
// nVSYNC falling edges and optionally auto-cycles patterns 1..3.
module tp_sequencer #(
  parameter int AUTO_FRAMES_NTSC = 300,
  parameter int AUTO_FRAMES_PAL  = 250
) (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       palmode,
  input  logic       vdata_sync_valid_i,
  input  logic [3:0] vdata_sync_i,
  input  logic       cfg_req,
  input  logic [1:0] cfg_pattern,
  input  logic       cfg_auto,
  output logic       cfg_ack,
  output logic [1:0] tp_sel,
  output logic       tp_en,
  output logic       frame_tick,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2
  } state_t;

  localparam logic [8:0] LIMIT_NTSC_M1 = 9'(AUTO_FRAMES_NTSC - 1);
  localparam logic [8:0] LIMIT_PAL_M1  = 9'(AUTO_FRAMES_PAL - 1);

  state_t     state_reg;
  logic       vs_prev_reg;
  logic [8:0] frame_cnt_reg;
  logic       auto_mode_reg;
  logic [1:0] req_pattern_reg;
  logic       req_auto_reg;

  logic       vs_edge;
  logic [8:0] limit_m1;
  logic [1:0] auto_next;
  logic [1:0] req_sel;
  logic       sync_unused;

  // Only nVSYNC matters here; the other sync bits pass through untouched elsewhere.
  assign sync_unused = ^vdata_sync_i[2:0];

  assign vs_edge   = vdata_sync_valid_i & vs_prev_reg & ~vdata_sync_i[3];
  assign limit_m1  = palmode ? LIMIT_PAL_M1 : LIMIT_NTSC_M1;
  assign auto_next = (tp_sel == 2'd3) ? 2'd1 : tp_sel + 2'd1;
  assign req_sel   = (req_auto_reg && req_pattern_reg == 2'd0) ? 2'd1 : req_pattern_reg;

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      state_reg       <= IDLE;
      vs_prev_reg     <= 1'b1;
      frame_cnt_reg   <= '0;
      auto_mode_reg   <= 1'b0;
      req_pattern_reg <= '0;
      req_auto_reg    <= 1'b0;
      cfg_ack         <= 1'b0;
      tp_sel          <= '0;
      tp_en           <= 1'b0;
      frame_tick      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      frame_tick <= vs_edge;
      if (vdata_sync_valid_i) begin
        vs_prev_reg <= vdata_sync_i[3];
      end

      // A request completing on the same edge overrides this below.
      if (auto_mode_reg && vs_edge) begin
        if (frame_cnt_reg >= limit_m1) begin
          frame_cnt_reg <= '0;
          tp_sel        <= auto_next;
          tp_en         <= (auto_next != 2'd0);
        end else if (frame_cnt_reg != 9'd511) begin
          frame_cnt_reg <= frame_cnt_reg + 9'd1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (cfg_req) begin
            req_pattern_reg <= cfg_pattern;
            req_auto_reg    <= cfg_auto;
            busy            <= 1'b1;
            state_reg       <= PENDING;
          end
        end
        PENDING: begin
          if (vs_edge) begin
            tp_sel        <= req_sel;
            tp_en         <= (req_sel != 2'd0);
            auto_mode_reg <= req_auto_reg;
            frame_cnt_reg <= '0;
            cfg_ack       <= 1'b1;
            busy          <= 1'b0;
            state_reg     <= ACK;
          end
        end
        ACK: begin
          if (!cfg_req) begin
            cfg_ack   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
